// File: rtl/sargantana_icache_pkg.sv
// Shared geometry and controller state encoding for the Sargantana instruction cache.
package sargantana_icache_pkg;

    localparam int unsigned ICACHE_N_WAY     = 4;
    localparam int unsigned ICACHE_IDX_WIDTH = 6;
    localparam int unsigned ICACHE_TAG_WIDTH = 20;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        MISS_REQ,
        MISS_WAIT,
        FILL,
        REPLAY,
        FLUSH
    } ictrl_state_t;

endpackage

// File: rtl/sargantana_icache_replace.sv
// Victim way selection: lowest-index invalid way, else a round-robin pointer
// that advances on each fill that consumed it.
module sargantana_icache_replace
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned N_WAY = ICACHE_N_WAY
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_WAY-1:0] valid_bits_i,
    input  logic             update_i,
    input  logic             clear_i,
    output logic [N_WAY-1:0] victim_o,
    output logic             use_rr_o
);

    localparam int unsigned PW = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    logic [PW-1:0] rr_q;
    logic          found;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (clear_i) begin
            rr_q <= '0;
        end else if (update_i) begin
            rr_q <= rr_q + PW'(1);
        end
    end

    always_comb begin
        victim_o = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_WAY; i++) begin
            if (!found && !valid_bits_i[i]) begin
                victim_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
        use_rr_o = &valid_bits_i;
        if (use_rr_o) begin
            victim_o = N_WAY'(1) << rr_q;
        end
    end

endmodule

// File: rtl/sargantana_icache_ctrl.sv
// Instruction cache sequencing controller: lookup, miss refill, replay and
// whole-cache invalidation.
module sargantana_icache_ctrl
    import sargantana_icache_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ICACHE_IDX_WIDTH-1:0] req_idx_i,
    input  logic                        kill_i,
    input  logic                        paddr_valid_i,
    input  logic [ICACHE_TAG_WIDTH-1:0] paddr_tag_i,
    input  logic [ICACHE_N_WAY-1:0]     cline_hit_i,
    input  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i,
    output logic                        cmp_enable_o,
    output logic                        ram_req_o,
    output logic                        ram_we_o,
    output logic [ICACHE_IDX_WIDTH-1:0] ram_idx_o,
    output logic [ICACHE_N_WAY-1:0]     ram_way_o,
    output logic                        valid_clr_o,
    output logic                        ifill_req_valid_o,
    input  logic                        ifill_req_ready_i,
    output logic [ICACHE_TAG_WIDTH-1:0] ifill_req_tag_o,
    input  logic                        ifill_resp_valid_i,
    output logic                        resp_valid_o,
    input  logic                        flush_i,
    output logic                        flush_done_o
);

    ictrl_state_t                state_q;
    logic [ICACHE_IDX_WIDTH-1:0] idx_q;
    logic [ICACHE_IDX_WIDTH-1:0] flush_cnt_q;
    logic [ICACHE_TAG_WIDTH-1:0] tag_q;
    logic [ICACHE_N_WAY-1:0]     victim_q;
    logic [ICACHE_N_WAY-1:0]     victim;
    logic                        use_rr;
    logic                        rr_used_q;
    logic                        killed_q;
    logic                        flush_pend_q;
    logic                        flush_req;
    logic                        hit;
    logic                        accept;
    logic                        rr_update;
    logic                        rr_clear;

    assign flush_req       = flush_pend_q | flush_i;
    assign hit             = |cline_hit_i;
    assign rr_update       = (state_q == FILL) && rr_used_q;
    assign rr_clear        = (state_q == FLUSH);
    assign ifill_req_tag_o = tag_q;

    sargantana_icache_replace #(
        .N_WAY(ICACHE_N_WAY)
    ) u_replace (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_bits_i(way_valid_bits_i),
        .update_i    (rr_update),
        .clear_i     (rr_clear),
        .victim_o    (victim),
        .use_rr_o    (use_rr)
    );

    always_comb begin
        req_ready_o       = 1'b0;
        cmp_enable_o      = 1'b0;
        ram_req_o         = 1'b0;
        ram_we_o          = 1'b0;
        ram_idx_o         = idx_q;
        ram_way_o         = '0;
        valid_clr_o       = 1'b0;
        ifill_req_valid_o = 1'b0;
        resp_valid_o      = 1'b0;
        flush_done_o      = 1'b0;
        case (state_q)
            IDLE:      req_ready_o = !kill_i && !flush_req;
            COMPARE: begin
                cmp_enable_o = 1'b1;
                if (!kill_i && paddr_valid_i && hit) begin
                    resp_valid_o = 1'b1;
                    req_ready_o  = 1'b1;
                end
            end
            MISS_REQ:  ifill_req_valid_o = 1'b1;
            FILL: begin
                ram_we_o  = 1'b1;
                ram_way_o = victim_q;
            end
            REPLAY:    ram_req_o = 1'b1;
            FLUSH: begin
                valid_clr_o  = 1'b1;
                ram_idx_o    = flush_cnt_q;
                flush_done_o = &flush_cnt_q;
            end
            default: ;
        endcase
        // A fresh lookup reads the RAM in the same cycle it is accepted.
        accept = req_valid_i && req_ready_o;
        if (accept) begin
            ram_req_o = 1'b1;
            ram_idx_o = req_idx_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            flush_cnt_q  <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            rr_used_q    <= 1'b0;
            killed_q     <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= (state_q == IDLE) ? 1'b0 : flush_req;
            if (accept) begin
                idx_q <= req_idx_i;
            end
            case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= '0;
                    end else if (accept) begin
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (kill_i) begin
                        state_q <= IDLE;
                    end else if (paddr_valid_i) begin
                        if (hit) begin
                            state_q <= accept ? COMPARE : IDLE;
                        end else begin
                            tag_q     <= paddr_tag_i;
                            victim_q  <= victim;
                            rr_used_q <= use_rr;
                            state_q   <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    // A kill coinciding with the handshake cannot retract the
                    // refill, so it is handled like a kill while waiting.
                    if (ifill_req_ready_i) begin
                        state_q  <= MISS_WAIT;
                        killed_q <= kill_i;
                    end else if (kill_i) begin
                        state_q <= IDLE;
                    end
                end
                MISS_WAIT: begin
                    if (kill_i) begin
                        killed_q <= 1'b1;
                    end
                    if (ifill_resp_valid_i) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    state_q  <= (killed_q || kill_i) ? IDLE : REPLAY;
                    killed_q <= 1'b0;
                end
                REPLAY:  state_q <= kill_i ? IDLE : COMPARE;
                FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + ICACHE_IDX_WIDTH'(1);
                    if (&flush_cnt_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Transaction-level bench for the icache controller: each transaction expands
// into a per-cycle timeline of expected outputs checked on the falling edge.
module tb_sargantana_icache_ctrl;
    import sargantana_icache_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, kill_i, paddr_valid_i;
    logic [5:0]  req_idx_i, ram_idx_o;
    logic [19:0] paddr_tag_i, ifill_req_tag_o;
    logic [3:0]  cline_hit_i, way_valid_bits_i, ram_way_o;
    logic        cmp_enable_o, ram_req_o, ram_we_o, valid_clr_o;
    logic        ifill_req_valid_o, ifill_req_ready_i, ifill_resp_valid_i;
    logic        resp_valid_o, flush_i, flush_done_o;

    always #5 clk_i = ~clk_i;

    sargantana_icache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_idx_i(req_idx_i),
        .kill_i(kill_i), .paddr_valid_i(paddr_valid_i), .paddr_tag_i(paddr_tag_i),
        .cline_hit_i(cline_hit_i), .way_valid_bits_i(way_valid_bits_i),
        .cmp_enable_o(cmp_enable_o), .ram_req_o(ram_req_o), .ram_we_o(ram_we_o),
        .ram_idx_o(ram_idx_o), .ram_way_o(ram_way_o), .valid_clr_o(valid_clr_o),
        .ifill_req_valid_o(ifill_req_valid_o), .ifill_req_ready_i(ifill_req_ready_i),
        .ifill_req_tag_o(ifill_req_tag_o), .ifill_resp_valid_i(ifill_resp_valid_i),
        .resp_valid_o(resp_valid_o), .flush_i(flush_i), .flush_done_o(flush_done_o)
    );

    logic        e_ready, e_cmp, e_ramreq, e_we, e_clr, e_ifv, e_resp, e_done;
    logic [5:0]  e_idx;
    logic [3:0]  e_way;
    logic [19:0] e_tag;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          rr_m = 0;
    logic [3:0]  last_fill_way = 4'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready_o), 32'(e_ready));
            chk("cmp_enable", 32'(cmp_enable_o), 32'(e_cmp));
            chk("ram_req", 32'(ram_req_o), 32'(e_ramreq));
            chk("ram_we", 32'(ram_we_o), 32'(e_we));
            chk("valid_clr", 32'(valid_clr_o), 32'(e_clr));
            chk("ifill_valid", 32'(ifill_req_valid_o), 32'(e_ifv));
            chk("resp_valid", 32'(resp_valid_o), 32'(e_resp));
            chk("flush_done", 32'(flush_done_o), 32'(e_done));
            if (e_ramreq || e_we || e_clr) chk("ram_idx", 32'(ram_idx_o), 32'(e_idx));
            if (e_we) begin
                chk("ram_way", 32'(ram_way_o), 32'(e_way));
                last_fill_way = ram_way_o;
            end
            if (e_ifv) chk("ifill_tag", 32'(ifill_req_tag_o), 32'(e_tag));
        end
    end

    // Lowest invalid way, otherwise the current round-robin position.
    function automatic logic [3:0] victim_of(input logic [3:0] vb);
        for (int i = 0; i < 4; i++) if (!vb[i]) return 4'(1 << i);
        return 4'(1 << rr_m);
    endfunction

    // Idle inputs (with noise on don't-care fields) and all-zero expectations.
    task automatic clr();
        req_valid_i = 1'b0; req_idx_i = 6'($urandom); kill_i = 1'b0;
        paddr_valid_i = 1'b0; paddr_tag_i = 20'($urandom);
        cline_hit_i = 4'($urandom); way_valid_bits_i = 4'($urandom);
        ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b0; flush_i = 1'b0;
        e_ready = 1'b0; e_cmp = 1'b0; e_ramreq = 1'b0; e_we = 1'b0; e_clr = 1'b0;
        e_ifv = 1'b0; e_resp = 1'b0; e_done = 1'b0;
        e_idx = 6'd0; e_way = 4'd0; e_tag = 20'd0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
        clr();
    endtask

    task automatic idle_cyc();
        e_ready = 1'b1;
        cyc();
    endtask

    task automatic idle_kill();
        req_valid_i = 1'b1; kill_i = 1'b1;
        cyc();
    endtask

    task automatic hit_seq(input logic [5:0] i0, input int n, input int way, input int maxw);
        logic [5:0] idx;
        int w;
        idx = i0;
        req_valid_i = 1'b1; req_idx_i = idx; e_ready = 1'b1; e_ramreq = 1'b1; e_idx = idx;
        cyc();
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, maxw)) begin e_cmp = 1'b1; cyc(); end
            w = (way < 0) ? int'($urandom_range(0, 3)) : way;
            paddr_valid_i = 1'b1; cline_hit_i = 4'(1 << w);
            e_cmp = 1'b1; e_resp = 1'b1; e_ready = 1'b1;
            if (k < n - 1) begin
                idx = idx + 6'd1;
                req_valid_i = 1'b1; req_idx_i = idx; e_ramreq = 1'b1; e_idx = idx;
            end
            cyc();
        end
    endtask

    // kill_at: 0 none, 1 COMPARE, 2 MISS_REQ (needs h>0), 3 MISS_WAIT, 4 FILL
    task automatic miss(input logic [5:0] idx, input logic [19:0] tag, input logic [3:0] vb,
                        input int h, input int r, input int kill_at, input bit pend_flush);
        logic [3:0] v;
        bit used;
        req_valid_i = 1'b1; req_idx_i = idx; e_ready = 1'b1; e_ramreq = 1'b1; e_idx = idx;
        cyc();
        paddr_valid_i = 1'b1; paddr_tag_i = tag; cline_hit_i = 4'b0; way_valid_bits_i = vb;
        e_cmp = 1'b1;
        if (kill_at == 1) begin kill_i = 1'b1; cyc(); return; end
        cyc();
        used = (vb == 4'hF);
        v = victim_of(vb);
        for (int i = 0; i <= h; i++) begin
            e_ifv = 1'b1; e_tag = tag; ifill_req_ready_i = (i == h);
            if (kill_at == 2 && i == 0 && h > 0) begin kill_i = 1'b1; cyc(); return; end
            cyc();
        end
        for (int i = 0; i <= r; i++) begin
            ifill_resp_valid_i = (i == r);
            if (kill_at == 3 && i == 0) kill_i = 1'b1;
            if (pend_flush && i == 0) flush_i = 1'b1;
            cyc();
        end
        e_we = 1'b1; e_idx = idx; e_way = v;
        if (kill_at == 4) kill_i = 1'b1;
        cyc();
        if (used) rr_m = (rr_m + 1) % 4;
        if (kill_at >= 3) return;
        e_ramreq = 1'b1; e_idx = idx;
        cyc();
        paddr_valid_i = 1'b1; paddr_tag_i = tag; cline_hit_i = v;
        e_cmp = 1'b1; e_resp = 1'b1; e_ready = 1'b1;
        cyc();
    endtask

    task automatic flush_seq(input bit pulse, input bit with_req);
        flush_i = pulse; req_valid_i = with_req;
        cyc();
        for (int k = 0; k < 64; k++) begin
            e_clr = 1'b1; e_idx = 6'(k); e_done = (k == 63); req_valid_i = with_req;
            cyc();
        end
        rr_m = 0;
    endtask

    task automatic reset_mid_miss();
        req_valid_i = 1'b1; req_idx_i = 6'd9; e_ready = 1'b1; e_ramreq = 1'b1; e_idx = 6'd9;
        cyc();
        paddr_valid_i = 1'b1; paddr_tag_i = 20'hABCDE; cline_hit_i = 4'b0;
        way_valid_bits_i = 4'b0001; e_cmp = 1'b1;
        cyc();
        e_ifv = 1'b1; e_tag = 20'hABCDE;
        cyc();
        rst_i = 1'b1;
        e_ready = 1'b1;
        #1;
        chk("rst_ifill_drop", 32'(ifill_req_valid_o), 32'd0);
        chk("rst_cmp_drop", 32'(cmp_enable_o), 32'd0);
        cyc();
        rst_i = 1'b0;
        rr_m = 0;
        idle_cyc();
    endtask

    initial begin
        int kind, ka, h, r;
        bit pf, wr;
        rst_i = 1'b1;
        clr();
        chk_en = 1'b1;
        repeat (2) idle_cyc();
        rst_i = 1'b0;
        repeat (2) idle_cyc();

        hit_seq(6'd5, 2, 2, 0);
        idle_cyc();

        miss(6'd5, 20'h01234, 4'b0011, 3, 1, 0, 1'b0);
        chk("cold_victim", 32'(last_fill_way), 32'h4);
        idle_cyc();

        for (int i = 0; i < 5; i++) begin
            miss(6'd7, 20'h00777, 4'b1111, 0, 0, 0, 1'b0);
            chk("rr_victim", 32'(last_fill_way), 32'(4'b0001 << (i % 4)));
        end

        miss(6'd3, 20'h00333, 4'b0111, 1, 2, 3, 1'b0);
        chk("kill_wait_fill", 32'(last_fill_way), 32'h8);
        idle_cyc();
        miss(6'd4, 20'h00444, 4'b0000, 0, 0, 1, 1'b0);
        idle_cyc();
        idle_kill();

        flush_seq(1'b1, 1'b1);
        hit_seq(6'($urandom), 1, -1, 1);
        miss(6'd8, 20'h00888, 4'b1111, 0, 0, 0, 1'b0);
        chk("rr_after_flush", 32'(last_fill_way), 32'h1);

        reset_mid_miss();
        miss(6'd10, 20'h00AAA, 4'b1111, 0, 0, 0, 1'b0);
        chk("rr_after_reset", 32'(last_fill_way), 32'h1);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                hit_seq(6'($urandom), $urandom_range(1, 4), -1, 2);
            end else if (kind < 8) begin
                ka = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
                h = $urandom_range(0, 3);
                r = $urandom_range(0, 3);
                if (ka == 2 && h == 0) h = 1;
                pf = (ka == 0) && ($urandom_range(0, 7) == 0);
                miss(6'($urandom), 20'($urandom), 4'($urandom), h, r, ka, pf);
                if (pf) begin
                    wr = 1'($urandom);
                    flush_seq(1'b0, wr);
                    if (wr) hit_seq(6'($urandom), 1, -1, 1);
                end
            end else if (kind == 8) begin
                if ($urandom_range(0, 3) == 0) flush_seq(1'b1, 1'($urandom));
                else idle_kill();
            end else begin
                idle_cyc();
            end
        end
        idle_cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_ctrl.md
# sargantana_icache_ctrl

Sequencing controller for the Sargantana instruction cache. Accepts fetch requests, drives tag/data RAM reads, enables the tag-compare/way-select checker, and handles misses: it issues a line refill, picks a victim way and writes it back. It also runs whole-cache invalidation on flush. It sits between the fetch stage and the existing tag-compare checker, RAMs and L2 refill port.

## Interface
- ICACHE_N_WAY, 4, number of ways (power of two)
- ICACHE_IDX_WIDTH, 6, set index width (64 sets)
- ICACHE_TAG_WIDTH, 20, physical tag width
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_idx_i  in  ICACHE_IDX_WIDTH  set index of request
- kill_i  in  1  abort current request
- paddr_valid_i  in  1  translated tag available
- paddr_tag_i  in  ICACHE_TAG_WIDTH  physical tag
- cline_hit_i  in  ICACHE_N_WAY  per-way hit from checker
- way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the set being read
- cmp_enable_o  out  1  checker compare enable
- ram_req_o  out  1  tag/data RAM read strobe
- ram_we_o  out  1  RAM write strobe
- ram_idx_o  out  ICACHE_IDX_WIDTH  RAM set index
- ram_way_o  out  ICACHE_N_WAY  one-hot way for write
- valid_clr_o  out  1  clear all valid bits of ram_idx_o
- ifill_req_valid_o  out  1  refill request
- ifill_req_ready_i  in  1  refill request accepted
- ifill_req_tag_o  out  ICACHE_TAG_WIDTH  refill tag
- ifill_resp_valid_i  in  1  refill line returned (data routed to RAM directly)
- resp_valid_o  out  1  hit data valid on checker output
- flush_i  in  1  invalidate request (pulse)
- flush_done_o  out  1  one-cycle pulse at end of flush

## Operation
- States: IDLE, COMPARE, MISS_REQ, MISS_WAIT, FILL, REPLAY, FLUSH.
- IDLE: req_ready_o=1 unless a flush is pending. On accept: ram_req_o=1 with ram_idx_o=req_idx_i, and the index is registered. Go to COMPARE.
- COMPARE: cmp_enable_o=1.
  - paddr_valid_i=0: stay; RAM output is held.
  - Hit (|cline_hit_i): resp_valid_o=1 and req_ready_o=1 (back-to-back). On accept, stay in COMPARE with a new RAM read; otherwise go to IDLE.
  - Miss: register the tag and the victim way, then go to MISS_REQ.
- MISS_REQ: hold ifill_req_valid_o with a stable tag until ifill_req_ready_i, then go to MISS_WAIT.
- MISS_WAIT: on ifill_resp_valid_i, go to FILL.
- FILL: one cycle of ram_we_o=1 with the registered idx/victim, then REPLAY.
- REPLAY: ram_req_o=1 on the same idx, then COMPARE. The replay guarantees a hit.
- Victim selection: lowest-index invalid way. If all ways are valid, use a round-robin pointer, which increments (wrapping) on each fill that used it.
- kill_i:
  - In COMPARE or MISS_REQ before the handshake: go to IDLE, no response.
  - In MISS_WAIT or FILL: set a killed flag. The fill still completes, then go to IDLE without REPLAY.
  - kill_i with req_valid_i in the same cycle: the kill wins and nothing is accepted.
- flush_i: latched as pending and serviced only from IDLE. FLUSH walks idx 0..2^IDX-1, driving valid_clr_o=1 with ram_idx_o each cycle. The round-robin pointer is reset to 0 and flush_done_o pulses in the final-index cycle. req_ready_o=0 throughout.
- Simultaneous flush_i and req_valid_i in IDLE: the flush wins.

## Timing
- Reset: state IDLE, round-robin pointer 0, flush pending 0, killed 0. req_ready_o=1; all other outputs 0.
- Hit latency: accept in cycle N, resp_valid_o in N+1 if the tag is ready. Throughput is 1/cycle on hits.
- Miss cost:
  - 1 cycle COMPARE
  - ≥1 cycle MISS_REQ (handshake)
  - ≥1 cycle MISS_WAIT
  - 1 cycle FILL
  - 1 cycle REPLAY
  - 1 cycle COMPARE hit
  - Minimum miss-to-resp is 6 cycles after accept.
- Flush: exactly 2^ICACHE_IDX_WIDTH cycles in FLUSH; returns to IDLE the next cycle.
- Reset asserted mid-operation: immediate return to IDLE and all pulses drop. Any outstanding refill is abandoned; the L2 side is reset by the same rst_i.

## Structure
- sargantana_icache_pkg: ICACHE_N_WAY, ICACHE_IDX_WIDTH, ICACHE_TAG_WIDTH, and the ictrl_state_t enum.
- Sub-module sargantana_icache_replace: victim select (priority-invalid plus round-robin pointer), with inputs valid bits, update and clear, and one-hot victim output.
- Top: FSM, registered idx/tag/victim/killed, flush counter.

## Test plan
- Hit: accept idx 5 with tag 0x1234 hitting way 2 → cmp_enable_o and resp_valid_o one cycle later; no ifill_req. Back-to-back hits on idx 5 then 6 → two consecutive resp_valid_o.
- Cold miss: valid bits 0011, miss → ifill_req_tag_o=0x1234 held 3 cycles until ready. After response: ram_we_o with ram_way_o=0100, then REPLAY, then resp_valid_o.
- Full set: valid bits 1111, four consecutive misses on idx 7 → victims 0001, 0010, 0100, 1000, then 0001 again (wrap).
- Kill in MISS_WAIT → FILL write still occurs; no REPLAY and no resp_valid_o; IDLE next cycle. Kill in COMPARE → IDLE, no ifill_req.
- Flush with concurrent req_valid_i: flush wins. 64 cycles of valid_clr_o with idx 0..63, flush_done_o at idx 63, round-robin pointer back to 0, then the request is accepted.
- rst_i asserted in MISS_REQ → outputs zero immediately and req_ready_o=1 after release.
